// File: rtl/serial_to_word_deserializer.sv
// serial_to_word_deserializer: packs a serial bit stream into DATA_W-bit words
// and presents them on a valid/ready port, with one word of skid capacity in the shift register.
module serial_to_word_deserializer #(
    parameter int DATA_W    = 16,
    parameter bit MSB_FIRST = 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    output logic              data_ready_o,
    output logic [DATA_W-1:0] deser_data_o,
    output logic              deser_data_val_o,
    input  logic              deser_ready_i
);
    localparam int CW = $clog2(DATA_W) + 1;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg, out_word, word;
    logic              out_valid, acc, pop, free, full, last;
    assign full             = cnt == CW'(DATA_W);
    assign last             = cnt == CW'(DATA_W - 1);
    assign data_ready_o     = !full;
    assign deser_data_o     = out_word;
    assign deser_data_val_o = out_valid;
    assign acc              = data_val_i & data_ready_o;
    assign pop              = out_valid & deser_ready_i;
    assign free             = !out_valid | pop;
    assign word             = MSB_FIRST ? {shreg[DATA_W-2:0], data_i} : {data_i, shreg[DATA_W-1:1]};
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt       <= '0;
            shreg     <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
        end else if (full && free) begin
            out_word  <= shreg;
            out_valid <= 1'b1;
            cnt       <= '0;
        end else if (acc && last && free) begin
            out_word  <= word;
            out_valid <= 1'b1;
            cnt       <= '0;
        end else if (acc && last) begin
            // slot still occupied: park the finished word in shreg and stall the source
            shreg <= word;
            cnt   <= CW'(DATA_W);
        end else begin
            if (acc) begin
                shreg <= word;
                cnt   <= cnt + 1'b1;
            end
            if (pop) out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/serial_to_word_deserializer.md
Name: serial_to_word_deserializer

Overview:
- Collects a serial bit stream into DATA_W-bit words.
- Presents each word on a valid/ready output port to the bit population counter stage downstream.
- Holds a completed word stable until the consumer accepts it.
- Applies backpressure to the serial source only when both the shift register and the output slot are occupied.

Parameters:
- DATA_W, 16, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, bit order. 1: the first accepted bit lands in deser_data_o[DATA_W-1]. 0: the first accepted bit lands in deser_data_o[0].

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- srst_i  input  1  synchronous, active-high reset.
- data_i  input  1  serial data bit.
- data_val_i  input  1  data_i is valid this cycle.
- data_ready_o  output  1  deserializer accepts a bit this cycle.
- deser_data_o  output  DATA_W  assembled word.
- deser_data_val_o  output  1  deser_data_o holds an unconsumed word.
- deser_ready_i  input  1  consumer takes the word this cycle.

Behaviour:
- Internal state:
  - shreg: DATA_W bits.
  - cnt: 0..DATA_W, $clog2(DATA_W)+1 bits.
  - out_word: DATA_W bits.
  - out_valid: 1 bit.
- Reset (srst_i=1 at an edge): cnt=0, shreg=0, out_word=0, out_valid=0.
  - Resulting outputs: data_ready_o=1, deser_data_val_o=0, deser_data_o=0.
  - Reset mid-word discards the partial word and any pending output word. Reset has priority over all other events.
- Output mapping:
  - data_ready_o = (cnt != DATA_W). It is a function of registers only, with no combinational path from any input.
  - deser_data_o = out_word; deser_data_val_o = out_valid.
- Events per cycle:
  - acc = data_val_i & data_ready_o.
  - pop = out_valid & deser_ready_i.
  - free = !out_valid | pop.
- Shift on acc:
  - MSB_FIRST=1: shreg <= {shreg[DATA_W-2:0], data_i}.
  - MSB_FIRST=0: shreg <= {data_i, shreg[DATA_W-1:1]}.
  - "word" denotes this post-shift value.
- Counter cases, in priority order:
  1. cnt==DATA_W (stalled) and free: out_word<=shreg, out_valid<=1, cnt<=0. No bit is accepted this cycle because data_ready_o=0.
  2. acc and cnt==DATA_W-1 and free: out_word<=word, out_valid<=1, cnt<=0. This is a same-edge handoff with zero bubble.
  3. acc and cnt==DATA_W-1 and !free: shreg<=word, cnt<=DATA_W. The block stalls and data_ready_o drops next cycle.
  4. acc otherwise: shift, cnt<=cnt+1.
  5. pop with no load in this cycle: out_valid<=0.
- Latency and throughput:
  - deser_data_val_o rises the cycle after the edge that accepts the last bit, provided the slot is free.
  - Sustained throughput is 1 bit/cycle with no gaps when deser_ready_i=1.
- Output stability:
  - While out_valid=1 and deser_ready_i=0, out_word is unchanged.
  - After a pop with no reload, out_word retains its last value; it is don't-care with valid low.
- data_i is ignored when data_val_i=0 or data_ready_o=0. cnt and shreg are unchanged in that case.
- Simultaneous pop and load in the same cycle: out_valid stays 1 and out_word takes the new word.
- Capacity: at most one complete word in shreg plus one in out_word. The bit source is blocked only in the cnt==DATA_W state.

Test Plan:
- Reset, then DATA_W=8, MSB_FIRST=1, deser_ready_i=1; stream bits 1,0,1,1,0,0,1,0 on consecutive cycles -> deser_data_o=8'hB2 with a single-cycle deser_data_val_o pulse, one cycle after the 8th bit; data_ready_o stays 1 throughout.
- Same stream with MSB_FIRST=0 -> deser_data_o=8'h4D.
- Back-to-back words 8'hFF then 8'h01 with no gaps, deser_ready_i=1 -> valid pulses exactly 8 cycles apart; no data_ready_o deassertion.
- Hold deser_ready_i=0 and stream 16 bits (8'hA5, 8'h3C) -> first word held stable with valid high; after bit 16, data_ready_o=0; a 17th offered bit is ignored; raise deser_ready_i for one cycle -> 8'hA5 popped, 8'h3C loaded with valid still 1, and data_ready_o=1 the next cycle.
- Gappy input: data_val_i toggles 1,0 every cycle for word 8'h81 -> correct word produced; bits on data_val_i=0 cycles ignored.
- Assert srst_i after 5 bits of a word with a pending unconsumed word -> next cycle valid=0, deser_data_o=0, data_ready_o=1; a following full 8-bit stream of 8'h5A produces exactly 8'h5A.
